heap_ram_arbiter: RTL

- Shares one per-level heap dual-port RAM between NREQ requesters: sorter pipeline stages, host loader and debug readback.
- Port A: round-robin arbitrated single-word read/write channel with tagged read responses.
- Port B: owned by a clear engine that sweeps the level RAM to INIT_VALUE (the empty-node sentinel) before a sort.
- Sits between the level's stage logic and its RAM instance; the RAM has 1-cycle registered read.

---
 rtl/heap_ram_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/heap_ram_arbiter.sv
// -----------------------------------------------------------------------------
// heap_ram_arbiter
//
// Shares one heap-level dual-port RAM (1-cycle registered read) between NREQ
// requesters (sorter stages, host loader, debug readback).
//
//   Port A : round-robin arbitrated single-word read/write channel. Reads are
//            answered one cycle after the grant with the requester id attached.
//   Port B : owned by the clear engine, which sweeps the level RAM to
//            INIT_VALUE (the empty-node sentinel) two words per cycle, port A
//            taking even addresses and port B odd ones.
//
// Handshake: a request is issued in a cycle where req_valid[i] & req_ready[i];
// the requester holds valid/we/addr/data stable until then. req_ready is
// combinational and at most one-hot. rsp has no backpressure.
//
// Optional build macro: HEAP_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest asserted index wins, ptr stays at 0
//   undefined -> round-robin starting from ptr
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_we [NREQ]         per-requester request, 1 = write
//   req_addr/req_data (packed)      requester i uses slice i
//   req_ready [NREQ]                one-hot grant
//   rsp_valid/rsp_id/rsp_data       tagged read response (rsp_data = ram_q_a)
//   clear_start/clear_busy/clear_done  sweep control and status
//   ram_addr_a/ram_data_a/ram_we_a/ram_q_a   RAM port A
//   ram_addr_b/ram_data_b/ram_we_b           RAM port B
//   clear_busy doubles as the observable FSM state (1 = CLEAR).
// -----------------------------------------------------------------------------
module heap_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    input  logic                       clear_start,
    output logic                       clear_busy,
    output logic                       clear_done,
    output logic [ADDR_WIDTH-1:0]      ram_addr_a,
    output logic [DATA_WIDTH-1:0]      ram_data_a,
    output logic                       ram_we_a,
    input  logic [DATA_WIDTH-1:0]      ram_q_a,
    output logic [ADDR_WIDTH-1:0]      ram_addr_b,
    output logic [DATA_WIDTH-1:0]      ram_data_b,
    output logic                       ram_we_b
);

    localparam int MEM_SIZE  = 1 << LEVEL;
    // A one-entry level still needs one sweep cycle (port A only).
    localparam int SWEEP_LEN = (MEM_SIZE >= 2) ? (MEM_SIZE / 2) : 1;
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = ADDR_WIDTH'(SWEEP_LEN - 1);
    localparam bit HAS_PORT_B_SWEEP = (MEM_SIZE >= 2);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    logic [IDW-1:0]        ptr;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    logic                  grant_valid;
    logic [IDW-1:0]        grant_id;
    logic [IDW-1:0]        ptr_next;
    logic [IDW-1:0]        cand;
    int                    cand_sum;

    // ------------------------------------------------------------------
    // Grant search: first valid requester at ptr, ptr+1, ... (mod NREQ).
    // With fixed priority ptr is never advanced, so the search starts at 0.
    // No grant while sweeping or in the cycle the sweep is requested, so the
    // clear never collides with a port A access.
    // ------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        cand_sum    = 0;
        if (state == IDLE && !clear_start) begin
            for (int o = 0; o < NREQ; o++) begin
                cand_sum = int'(ptr) + o;
                if (cand_sum >= NREQ) begin
                    cand_sum = cand_sum - NREQ;
                end
                cand = IDW'(cand_sum);
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_id    = cand;
                end
            end
        end
    end

    assign req_ready = grant_valid ? (NREQ'(1) << grant_id) : '0;
    assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    assign rsp_data  = ram_q_a;

    // ------------------------------------------------------------------
    // Port A: sweep has priority (grant is already suppressed then),
    // otherwise the winner's request passes straight through.
    // ------------------------------------------------------------------
    always_comb begin
        ram_we_a   = 1'b0;
        ram_addr_a = '0;
        ram_data_a = '0;
        if (state == CLEAR) begin
            ram_we_a   = 1'b1;
            ram_addr_a = sweep_cnt << 1;
            ram_data_a = INIT_VALUE;
        end else if (grant_valid) begin
            ram_we_a   = req_we[grant_id];
            ram_addr_a = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            ram_data_a = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Port B: odd addresses of the sweep, idle otherwise.
    always_comb begin
        ram_we_b   = 1'b0;
        ram_addr_b = '0;
        ram_data_b = '0;
        if (state == CLEAR && HAS_PORT_B_SWEEP) begin
            ram_we_b   = 1'b1;
            ram_addr_b = (sweep_cnt << 1) | ADDR_WIDTH'(1);
            ram_data_b = INIT_VALUE;
        end
    end

    // ------------------------------------------------------------------
    // FSM, pointer, response tag and sweep counter.
    // A read granted in IDLE returns in the next cycle even if that cycle is
    // already part of a sweep: the response pipe is independent of state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            sweep_cnt  <= '0;
        end else begin
            clear_done <= 1'b0;
            rsp_valid  <= grant_valid && !req_we[grant_id];
            if (grant_valid && !req_we[grant_id]) begin
                rsp_id <= grant_id;
            end
            case (state)
                IDLE: begin
`ifndef HEAP_ARB_FIXED_PRIO_EN
                    if (grant_valid) begin
                        ptr <= ptr_next;
                    end
`endif
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        sweep_cnt  <= '0;
                    end
                end
                CLEAR: begin
                    // clear_start is ignored here by construction.
                    if (sweep_cnt == SWEEP_LAST) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        sweep_cnt  <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
